// File: rtl/aes_cbc_dechain.sv
// CBC/ECB un-chaining wrapper around a combinational AES decrypt core.
// One block in flight: accept, settle SETTLE_CYCLES edges, capture, hold output until taken.
module aes_cbc_dechain #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          MODE_CBC      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iv_load,
  input  logic [0:127] iv,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [0:127] ct_data,
  output logic [0:127] dec_in,
  input  logic [0:127] dec_out,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [0:127] pt_data,
  output logic         busy,
  output logic [31:0]  blk_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] chain_q, chain_d;
  logic [0:127] ct_q, ct_d;
  logic [0:127] pt_q, pt_d;
  logic         pt_vld_q, pt_vld_d;
  logic [31:0]  blk_q, blk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      chain_q  <= '0;
      ct_q     <= '0;
      pt_q     <= '0;
      pt_vld_q <= 1'b0;
      blk_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      ct_q     <= ct_d;
      pt_q     <= pt_d;
      pt_vld_q <= pt_vld_d;
      blk_q    <= blk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    ct_d     = ct_q;
    pt_d     = pt_q;
    pt_vld_d = pt_vld_q;
    blk_d    = blk_q;
    unique case (state_q)
      IDLE: begin
        // iv_load wins over a simultaneous ct_valid; ct_ready is already low then
        if (iv_load) begin
          chain_d = iv;
          blk_d   = 32'd0;
        end else if (ct_valid) begin
          ct_d    = ct_data;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pt_d     = MODE_CBC ? (dec_out ^ chain_q) : dec_out;
          chain_d  = ct_q;
          pt_vld_d = 1'b1;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (pt_ready) begin
          pt_vld_d = 1'b0;
          blk_d    = blk_q + 32'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ct_ready  = (state_q == IDLE) && !iv_load;
  assign dec_in    = ct_q;
  assign pt_valid  = pt_vld_q;
  assign pt_data   = pt_q;
  assign busy      = (state_q != IDLE);
  assign blk_count = blk_q;

endmodule

// File: doc/aes_cbc_dechain.md
Name: aes_cbc_dechain

Overview:
- Sequential wrapper directly downstream of the combinational AES decrypt datapath (`Decrypt`, key already applied).
- Accepts ciphertext blocks over a valid/ready handshake and registers each block onto the decrypt core input.
- Waits a fixed number of settle cycles for the combinational core, then captures its output and XORs it with the chaining value (IV or previous ciphertext).
- Emits plaintext over a valid/ready handshake and keeps a delivered-block count.

Parameters:
- SETTLE_CYCLES, 2: cycles allowed for the decrypt core output to settle; legal range 1..15.
- MODE_CBC, 1: 1 = CBC un-chaining; 0 = ECB passthrough (no XOR, chain register unused).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- iv_load  input  1  load `iv` into the chain register and clear `blk_count`; honoured only in IDLE.
- iv  input  [0:127]  initialisation vector.
- ct_valid  input  1  ciphertext block offered.
- ct_ready  output  1  block can be accepted.
- ct_data  input  [0:127]  ciphertext block.
- dec_in  output  [0:127]  registered ciphertext driving the decrypt core input.
- dec_out  input  [0:127]  decrypt core output.
- pt_valid  output  1  plaintext block available.
- pt_ready  input  1  downstream accepts plaintext.
- pt_data  output  [0:127]  plaintext block.
- busy  output  1  high whenever state is not IDLE.
- blk_count  output  32  number of plaintext blocks delivered since reset or the last iv_load.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; chain, ct_reg (= dec_in), pt_data and blk_count all 0.
  - pt_valid = 0; busy = 0.
  - A block in flight is discarded; no partial output appears after reset release.
- Handshake signals:
  - ct_ready = (state == IDLE) && !iv_load, purely combinational.
  - iv_load has priority over ct_valid in the same cycle.
- FSM states: IDLE, SETTLE, OUTPUT.
- IDLE:
  - iv_load = 1 at an edge: chain <= iv, blk_count <= 0, stay in IDLE.
  - Else ct_valid && ct_ready at an edge: ct_reg <= ct_data, cnt <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - dec_in holds ct_reg stable.
  - Each edge: if cnt != 0, cnt <= cnt-1.
  - At the edge where cnt == 0, capture and go to OUTPUT:
    - pt_data <= dec_out ^ chain when MODE_CBC = 1, or dec_out when MODE_CBC = 0.
    - chain <= ct_reg.
    - pt_valid <= 1.
- Latency: pt_valid rises exactly SETTLE_CYCLES edges after the ct acceptance edge.
- OUTPUT:
  - pt_valid and pt_data are held stable until pt_valid && pt_ready at an edge.
  - On that edge: pt_valid <= 0, blk_count <= blk_count + 1 (wraps modulo 2^32), go to IDLE.
  - pt_ready asserted before pt_valid has no effect.
- Throughput: one block per SETTLE_CYCLES+2 cycles minimum (IDLE acceptance cycle, SETTLE, OUTPUT). No overlap of blocks.
- Ignored inputs:
  - iv_load outside IDLE: chain and blk_count unchanged.
  - ct_valid outside IDLE: not accepted.
  - iv and ct_data are sampled only on their respective load/accept edges.
- Chaining continuity: the chain register persists across blocks until the next iv_load or reset.

Test Plan:
- Reset mid-SETTLE: assert rst with SETTLE_CYCLES = 2 → pt_valid = 0, busy = 0, dec_in = 0 and blk_count = 0 immediately; the next accepted block decodes normally.
- ECB (MODE_CBC = 0), key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a:
  - pt_data = 00112233445566778899aabbccddeeff.
  - pt_valid rises 2 edges after acceptance.
- CBC per NIST SP800-38A, key 2b7e151628aed2a6abf7158809cf4f3c, iv_load with IV 000102…0f:
  - ct1 7649abac8119b246cee98e9b12e9197d → pt 6bc1bee22e409f96e93d7e117393172a.
  - ct2 5086cb9b507219ee95db113a917678b2 → pt ae2d8a571e03ac9c9eb76fac45af8e51.
  - blk_count = 2.
- Backpressure: hold pt_ready = 0 for 5 cycles in OUTPUT → pt_data stable, ct_ready = 0, blk_count unchanged; pt_ready = 1 → blk_count increments once.
- iv_load in the same cycle as ct_valid → ct_ready = 0 that cycle, IV loaded; block accepted the next cycle. iv_load during SETTLE → ignored; the result still uses the old chain value.
- SETTLE_CYCLES = 1 and 15 → pt_valid rises exactly 1 and 15 edges after acceptance, respectively.
